// File: rtl/led_pkg.sv
// Shared types and constants for the RGB LED PWM sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        STATIC    = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } breath_state_t;

    typedef logic [7:0] duty_t;

    localparam int NUM_LED_CH = 3;
    localparam int CH_R       = 0;
    localparam int CH_G       = 1;
    localparam int CH_B       = 2;

    localparam duty_t DUTY_MAX = 8'hFF;

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow/active duty pair, brightness scaling, optional
// gamma shaping and the counter compare that produces the registered pwm bit.
// Build option: LED_PWM_GAMMA_EN adds a gamma stage (pwm latency 2 from cnt).
module led_pwm_channel
    import led_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  duty_t      wr_duty,
    input  logic       wrap,
    input  logic       breathing,
    input  logic [7:0] brightness,
    input  logic [7:0] cnt,
    output logic       pwm
);

    duty_t      shadow;
    duty_t      active;
    duty_t      eff_p0;
    duty_t      lvl_cmp;
    logic [7:0] cnt_cmp;

    // Scale a duty by global brightness: (d * (b + 1)) >> 8, never exceeds d.
    function automatic duty_t scale(input duty_t d, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, d} * ({8'd0, b} + 16'd1);
        return duty_t'(prod >> 8);
    endfunction

    // Shadow takes every write; active only changes at the period wrap so the
    // output never glitches mid-period. A write landing on the wrap goes straight through.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_en) shadow <= wr_duty;
            if (wrap)  active <= wr_en ? wr_duty : shadow;
        end
    end

    assign eff_p0 = breathing ? scale(active, brightness) : active;

`ifdef LED_PWM_GAMMA_EN
    duty_t      lvl_p1;
    logic [7:0] cnt_p1;

    // Square-law gamma; full scale stays full and any non-zero level stays visible.
    function automatic duty_t gamma(input duty_t e);
        logic [15:0] sq;
        duty_t       g;
        sq = {8'd0, e} * {8'd0, e};
        g  = duty_t'(sq >> 8);
        if (e == DUTY_MAX)
            g = DUTY_MAX;
        else if ((e != '0) && (g == '0))
            g = 8'd1;
        return g;
    endfunction

    // p0 -> p1: gamma level and the counter are delayed together so the compare stays aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_p1 <= '0;
            cnt_p1 <= '0;
        end else begin
            lvl_p1 <= gamma(eff_p0);
            cnt_p1 <= cnt;
        end
    end

    assign lvl_cmp = lvl_p1;
    assign cnt_cmp = cnt_p1;
`else
    assign lvl_cmp = eff_p0;
    assign cnt_cmp = cnt;
`endif

    // Compare stage: full scale is solid on, zero never fires.
    always_ff @(posedge clk) begin
        if (rst)
            pwm <= 1'b0;
        else
            pwm <= (lvl_cmp == DUTY_MAX) || (cnt_cmp < lvl_cmp);
    end

endmodule

// File: rtl/led_pwm_sequencer.sv
// RGB LED PWM sequencer: prescaler, 8-bit PWM counter, duty write port and
// the breathing brightness FSM; three led_pwm_channel instances make the bits.
// Build option: LED_PWM_GAMMA_EN enables per-channel gamma (see led_pwm_channel).
module led_pwm_sequencer
    import led_pkg::*;
#(
    parameter int PRESC_DIV      = 12,
    parameter int BREATH_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_chan,
    input  logic [7:0] wr_duty,
    input  logic       breathe_en,
    output logic [2:0] pwm,
    output logic       period_start,
    output logic [7:0] brightness
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int SW = (BREATH_PERIODS > 1) ? $clog2(BREATH_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(BREATH_PERIODS - 1);

    logic [PW-1:0]           presc;
    logic [7:0]              cnt;
    logic                    tick;
    logic                    wrap;
    logic                    accept;
    logic [NUM_LED_CH-1:0]   wr_en;
    logic                    breathing;

    breath_state_t           state;
    breath_state_t           state_nx;
    logic [7:0]              bright_nx;
    logic [SW-1:0]           step;
    logic [SW-1:0]           step_nx;

    assign tick         = (presc == PRESC_LAST);
    assign wrap         = tick && (cnt == 8'hFF);
    assign period_start = wrap;
    assign accept       = wr_valid && wr_ready;
    assign breathing    = (state != STATIC);

    // Prescaler and PWM counter; the counter advances once per prescaler tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) cnt <= cnt + 8'd1;
        end
    end

    // Write port is held off during reset and always ready afterwards.
    always_ff @(posedge clk) begin
        if (rst)
            wr_ready <= 1'b0;
        else
            wr_ready <= 1'b1;
    end

    for (genvar c = 0; c < NUM_LED_CH; c++) begin : g_ch
        assign wr_en[c] = accept && (wr_chan == 2'(c));

        led_pwm_channel u_ch (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (wr_en[c]),
            .wr_duty    (wr_duty),
            .wrap       (wrap),
            .breathing  (breathing),
            .brightness (brightness),
            .cnt        (cnt),
            .pwm        (pwm[c])
        );
    end

    // Breathing FSM state, brightness and period-step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STATIC;
            brightness <= 8'hFF;
            step       <= '0;
        end else begin
            state      <= state_nx;
            brightness <= bright_nx;
            step       <= step_nx;
        end
    end

    // Next-state logic: only evaluated at the wrap; disabling breathing beats a pending step,
    // and the ramps turn around exactly at 255 and 0 so brightness never wraps.
    always_comb begin
        state_nx  = state;
        bright_nx = brightness;
        step_nx   = step;
        if (wrap) begin
            case (state)
                STATIC: begin
                    if (breathe_en) begin
                        state_nx  = RAMP_UP;
                        bright_nx = 8'h00;
                        step_nx   = '0;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (!breathe_en) begin
                        state_nx  = STATIC;
                        bright_nx = 8'hFF;
                        step_nx   = '0;
                    end else if (step == STEP_LAST) begin
                        step_nx = '0;
                        if (state == RAMP_UP) begin
                            bright_nx = brightness + 8'd1;
                            if (brightness == 8'hFE) state_nx = RAMP_DOWN;
                        end else begin
                            bright_nx = brightness - 8'd1;
                            if (brightness == 8'h01) state_nx = RAMP_UP;
                        end
                    end else begin
                        step_nx = step + SW'(1);
                    end
                end
                default: begin
                    state_nx  = STATIC;
                    bright_nx = 8'hFF;
                    step_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Directed bench for led_pwm_sequencer: one DUT with PRESC_DIV=2 for duty,
// commit and reset behaviour, a second with PRESC_DIV=1 for the full breathing ramp.
`timescale 1ns/1ps
module tb_led_pwm_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_chan;
    logic [7:0] wr_duty;
    logic       breathe_en;
    logic [2:0] pwm;
    logic       period_start;
    logic [7:0] brightness;

    logic       wr_valid_f;
    logic       wr_ready_f;
    logic [1:0] wr_chan_f;
    logic [7:0] wr_duty_f;
    logic       breathe_en_f;
    logic [2:0] pwm_f;
    logic       period_start_f;
    logic [7:0] brightness_f;

    int checks = 0;
    int errors = 0;
    int h0, h1, h2, l1;
    logic [2:0] acc;

`ifdef LED_PWM_GAMMA_EN
    localparam int LAT       = 2;
    localparam int E_CH0_64  = 32;
    localparam int E_CH0_200 = 312;
    localparam int E_CH1_128 = 128;
    localparam int E_B2_R    = 2;
    localparam int E_B2_G    = 2;
    localparam int E_B2_B    = 2;
`else
    localparam int LAT       = 1;
    localparam int E_CH0_64  = 128;
    localparam int E_CH0_200 = 400;
    localparam int E_CH1_128 = 256;
    localparam int E_B2_R    = 4;
    localparam int E_B2_G    = 2;
    localparam int E_B2_B    = 4;
`endif

    led_pwm_sequencer #(.PRESC_DIV(2), .BREATH_PERIODS(1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_chan      (wr_chan),
        .wr_duty      (wr_duty),
        .breathe_en   (breathe_en),
        .pwm          (pwm),
        .period_start (period_start),
        .brightness   (brightness)
    );

    led_pwm_sequencer #(.PRESC_DIV(1), .BREATH_PERIODS(1)) u_fast (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid_f),
        .wr_ready     (wr_ready_f),
        .wr_chan      (wr_chan_f),
        .wr_duty      (wr_duty_f),
        .breathe_en   (breathe_en_f),
        .pwm          (pwm_f),
        .period_start (period_start_f),
        .brightness   (brightness_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Returns at the falling edge of the next wrap cycle (period_start high).
    task automatic wait_wrap(input string tag, input bit fast);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(negedge clk);
            if (fast ? period_start_f : period_start) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Called at the falling edge of a wrap cycle; counts high samples per channel over
    // the following full period, shifted by the pwm latency.
    task automatic measure(output int c0, output int c1, output int c2, output int lead1);
        bit run1;
        c0 = 0; c1 = 0; c2 = 0; lead1 = 0; run1 = 1'b1;
        repeat (LAT + 1) begin
            @(negedge clk);
            wr_valid = 1'b0;
        end
        for (int i = 0; i < 512; i++) begin
            if (pwm[0] === 1'b1) c0++;
            if (pwm[1] === 1'b1) c1++;
            if (pwm[2] === 1'b1) c2++;
            if (run1 && pwm[1] === 1'b1) lead1++;
            else run1 = 1'b0;
            @(negedge clk);
        end
    endtask

    // One-cycle write handshake, called at a falling edge.
    task automatic write(input logic [1:0] ch, input logic [7:0] d);
        wr_chan  = ch;
        wr_duty  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = 1'b0; wr_chan = 2'd0; wr_duty = 8'd0; breathe_en = 1'b0;
        wr_valid_f = 1'b0; wr_chan_f = 2'd0; wr_duty_f = 8'd0; breathe_en_f = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_bright", 32'(brightness), 32'd255);
        check("rst_pstart", 32'(period_start), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_pwm_f", 32'(pwm_f), 32'd0);
        check("rst_ready_f", 32'(wr_ready_f), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(wr_ready), 32'd1);
        check("bright_after_rst", 32'(brightness), 32'd255);

        // Basic duties: 64 / 0 / 255
        write(2'd0, 8'd64);
        write(2'd1, 8'd0);
        write(2'd2, 8'd255);
        check("pwm_before_commit", 32'(pwm), 32'd0);
        wait_wrap("t1_wrap", 1'b0);
        measure(h0, h1, h2, l1);
        check("t1_r_high", 32'(h0), 32'(E_CH0_64));
        check("t1_g_high", 32'(h1), 32'd0);
        check("t1_b_high", 32'(h2), 32'd512);

        // Last write in a period wins; channel 3 accepted without effect
        write(2'd0, 8'd10);
        write(2'd0, 8'd200);
        write(2'd3, 8'd77);
        wait_wrap("t2_wrap", 1'b0);
        measure(h0, h1, h2, l1);
        check("t2_r_high", 32'(h0), 32'(E_CH0_200));
        check("t2_g_high", 32'(h1), 32'd0);
        check("t2_b_high", 32'(h2), 32'd512);

        // Write landing on the wrap cycle commits immediately
        wait_wrap("t3_wrap", 1'b0);
        wr_chan = 2'd1; wr_duty = 8'd128; wr_valid = 1'b1;
        measure(h0, h1, h2, l1);
        check("t3_g_high", 32'(h1), 32'(E_CH1_128));
        check("t3_g_lead", 32'(l1), 32'(E_CH1_128));
        check("t3_r_high", 32'(h0), 32'(E_CH0_200));

        // Breathing on the main DUT: brightness 0, 1, 2, 3 on successive periods
        write(2'd0, 8'd255);
        breathe_en = 1'b1;
        wait_wrap("t4_wrap0", 1'b0);
        measure(h0, h1, h2, l1);
        check("t4_b0_r", 32'(h0), 32'd0);
        check("t4_b0_g", 32'(h1), 32'd0);
        check("t4_b0_b", 32'(h2), 32'd0);
        check("t4_bright1", 32'(brightness), 32'd1);
        wait_wrap("t4_wrap2", 1'b0);
        measure(h0, h1, h2, l1);
        check("t4_b2_r", 32'(h0), 32'(E_B2_R));
        check("t4_b2_g", 32'(h1), 32'(E_B2_G));
        check("t4_b2_b", 32'(h2), 32'(E_B2_B));
        check("t4_bright3", 32'(brightness), 32'd3);
        breathe_en = 1'b0;
        wait_wrap("t4_wrap4", 1'b0);
        @(negedge clk);
        check("t4_static_bright", 32'(brightness), 32'd255);
        wait_wrap("t4_wrap5", 1'b0);
        measure(h0, h1, h2, l1);
        check("t4_static_r", 32'(h0), 32'd512);
        check("t4_static_g", 32'(h1), 32'(E_CH1_128));
        check("t4_static_b", 32'(h2), 32'd512);

        // Full ramp on the fast DUT: 0..255 then down 254, 253, 252, then stop
        breathe_en_f = 1'b1;
        wait_wrap("f_wrap", 1'b1);
        for (int i = 0; i < 259; i++) begin
            @(negedge clk);
            check("f_bright", 32'(brightness_f), (i <= 255) ? 32'(i) : 32'(510 - i));
            wait_wrap("f_wrap", 1'b1);
        end
        breathe_en_f = 1'b0;
        @(negedge clk);
        check("f_stop_bright", 32'(brightness_f), 32'd255);
        wait_wrap("f_wrap_static", 1'b1);
        @(negedge clk);
        check("f_static_hold", 32'(brightness_f), 32'd255);

        // Reset in the middle of a period
        wait_wrap("t5_wrap", 1'b0);
        repeat (100) @(negedge clk);
        check("t5_pwm_mid", 32'(pwm), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        check("t5_pwm_rst", 32'(pwm), 32'd0);
        check("t5_bright_rst", 32'(brightness), 32'd255);
        check("t5_ready_rst", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        acc = 3'b000;
        repeat (600) begin
            @(negedge clk);
            acc = acc | pwm;
        end
        check("t5_pwm_quiet", 32'(acc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
